sr_fifo_arbiter: RTL and testbench

Arbiter and occupancy controller that shares one `sr_fifo` instance between two requesters: port 0 is the CPU push/pop path and port 1 is a second master such as a DMA or debug agent. Each cycle it grants at most one requester round-robin and drives the FIFO enables, write data and read-data return. It tracks occupancy, drops illegal operations and latches sticky error flags. It sits between `sr_cpu`'s control/datapath and `sr_fifo`, and is reset by the same reset signal as `sr_fifo`.

---
 rtl/sr_fifo_arbiter_if.sv | 46 ++++
 rtl/sr_fifo_arbiter.sv | 101 ++++++++++
 tb/tb_sr_fifo_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_fifo_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared sr_fifo.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface sr_fifo_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  req0Push;
  logic                  req0Pop;
  logic [DATA_WIDTH-1:0] req0WData;
  logic                  gnt0;
  logic [DATA_WIDTH-1:0] req0RData;

  logic                  req1Push;
  logic                  req1Pop;
  logic [DATA_WIDTH-1:0] req1WData;
  logic                  gnt1;
  logic [DATA_WIDTH-1:0] req1RData;

  logic                  fifoWriteEnable;
  logic [DATA_WIDTH-1:0] fifoWriteData;
  logic                  fifoReadEnable;
  logic [DATA_WIDTH-1:0] fifoReadData;

  logic [CNT_WIDTH-1:0]  count;
  logic                  full;
  logic                  empty;
  logic                  errOverflow;
  logic                  errUnderflow;
  logic                  errClear;

  modport slave (
    input  req0Push, req0Pop, req0WData, req1Push, req1Pop, req1WData,
    input  fifoReadData, errClear,
    output gnt0, req0RData, gnt1, req1RData,
    output fifoWriteEnable, fifoWriteData, fifoReadEnable,
    output count, full, empty, errOverflow, errUnderflow
  );

  modport master (
    output req0Push, req0Pop, req0WData, req1Push, req1Pop, req1WData,
    output fifoReadData, errClear,
    input  gnt0, req0RData, gnt1, req1RData,
    input  fifoWriteEnable, fifoWriteData, fifoReadEnable,
    input  count, full, empty, errOverflow, errUnderflow
  );
endinterface

// File: rtl/sr_fifo_arbiter.sv
// Round-robin arbiter and occupancy tracker sharing one sr_fifo between two ports.
// state | meaning
// PRIO0 | port 0 wins when both ports request
// PRIO1 | port 1 wins when both ports request
module sr_fifo_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input logic              clk,
  input logic              reset,
  sr_fifo_arbiter_if.slave bus
);
  typedef enum logic {PRIO0 = 1'b0, PRIO1 = 1'b1} prioState_t;

  prioState_t            prio;
  prioState_t            prioNext;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  countNext;
  logic                  req0;
  logic                  req1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  selPush;
  logic                  selPop;
  logic [DATA_WIDTH-1:0] selWData;
  logic                  pushLegal;
  logic                  popLegal;
  logic                  ovfSet;
  logic                  udfSet;
  logic                  full;
  logic                  empty;
  logic                  errOverflow;
  logic                  errUnderflow;

  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio <= PRIO0;
    else       prio <= prioNext;
  end

  always_comb begin
    req0     = bus.req0Push | bus.req0Pop;
    req1     = bus.req1Push | bus.req1Pop;
    gnt0     = req0 & (~req1 | (prio == PRIO0));
    gnt1     = req1 & (~req0 | (prio == PRIO1));
    prioNext = prio;
    if (gnt0)      prioNext = PRIO1;
    else if (gnt1) prioNext = PRIO0;
  end

  always_comb begin
    selPush  = 1'b0;
    selPop   = 1'b0;
    selWData = '0;
    if (gnt0) begin
      selPush  = bus.req0Push;
      selPop   = bus.req0Pop;
      selWData = bus.req0WData;
    end else if (gnt1) begin
      selPush  = bus.req1Push;
      selPop   = bus.req1Pop;
      selWData = bus.req1WData;
    end
    // A simultaneous legal pop frees the slot, so push+pop is fine when full.
    popLegal  = selPop & ~empty;
    pushLegal = selPush & (~full | popLegal);
    ovfSet    = selPush & ~pushLegal;
    udfSet    = selPop & ~popLegal;
    countNext = count + CNT_WIDTH'(pushLegal) - CNT_WIDTH'(popLegal);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      errOverflow  <= 1'b0;
      errUnderflow <= 1'b0;
    end else begin
      count <= countNext;
      if (ovfSet)            errOverflow  <= 1'b1;
      else if (bus.errClear) errOverflow  <= 1'b0;
      if (udfSet)            errUnderflow <= 1'b1;
      else if (bus.errClear) errUnderflow <= 1'b0;
    end
  end

  assign bus.gnt0            = gnt0;
  assign bus.gnt1            = gnt1;
  assign bus.fifoWriteEnable = pushLegal;
  assign bus.fifoReadEnable  = popLegal;
  assign bus.fifoWriteData   = selWData;
  assign bus.req0RData       = (gnt0 & popLegal) ? bus.fifoReadData : '0;
  assign bus.req1RData       = (gnt1 & popLegal) ? bus.fifoReadData : '0;
  assign bus.count           = count;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.errOverflow     = errOverflow;
  assign bus.errUnderflow    = errUnderflow;
endmodule

// File: tb/tb_sr_fifo_arbiter.sv
// Directed bench for sr_fifo_arbiter: vector table plus hand sequences, with a
// small behavioural sr_fifo model supplying the head word.
module tb_sr_fifo_arbiter;
  logic clk;
  logic reset;
  int   nErr;
  int   nChecks;

  sr_fifo_arbiter_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();

  sr_fifo_arbiter #(.DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [8];
  logic [2:0]  wp;
  logic [2:0]  rp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (bus.fifoWriteEnable) begin
        mem[wp] <= bus.fifoWriteData;
        wp      <= wp + 3'd1;
      end
      if (bus.fifoReadEnable) rp <= rp + 3'd1;
    end
  end
  assign bus.fifoReadData = mem[rp];

  typedef struct {
    logic        push0, pop0;
    logic [31:0] wd0;
    logic        push1, pop1;
    logic [31:0] wd1;
    logic        clr;
    logic        g0, g1, we, re;
    logic [31:0] wdata, rd0, rd1;
    logic [3:0]  cnt;
    logic        ovf, udf;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic p0, input logic q0, input logic [31:0] d0,
    input logic p1, input logic q1, input logic [31:0] d1, input logic c,
    input logic g0, input logic g1, input logic we, input logic re,
    input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
    input logic [3:0] cnt, input logic ovf, input logic udf);
    vec_t v;
    v.push0 = p0; v.pop0 = q0; v.wd0 = d0;
    v.push1 = p1; v.pop1 = q1; v.wd1 = d1; v.clr = c;
    v.g0 = g0; v.g1 = g1; v.we = we; v.re = re;
    v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setIn(input logic p0, input logic q0, input logic [31:0] d0,
                       input logic p1, input logic q1, input logic [31:0] d1,
                       input logic c);
    bus.req0Push = p0; bus.req0Pop = q0; bus.req0WData = d0;
    bus.req1Push = p1; bus.req1Pop = q1; bus.req1WData = d1;
    bus.errClear = c;
  endtask

  task automatic chkState(input string nm, input logic [3:0] cnt,
                          input logic ovf, input logic udf);
    chk({nm, " count"}, 32'(bus.count), 32'(cnt));
    chk({nm, " full"},  32'(bus.full),  32'(cnt == 4'd8));
    chk({nm, " empty"}, 32'(bus.empty), 32'(cnt == 4'd0));
    chk({nm, " errOverflow"},  32'(bus.errOverflow),  32'(ovf));
    chk({nm, " errUnderflow"}, 32'(bus.errUnderflow), 32'(udf));
  endtask

  initial begin
    logic [31:0] k0, k1, expW;
    logic        expG0;
    nErr = 0;
    nChecks = 0;

    //          push0 pop0 wd0    push1 pop1 wd1   clr | g0 g1 we re wdata  rd0    rd1    cnt ovf udf
    vecs[0]  = mk(1, 0, 32'hA,  0, 0, 32'h0,  0,  1, 0, 1, 0, 32'hA,  32'h0,  32'h0,  1, 0, 0);
    vecs[1]  = mk(1, 0, 32'hB,  0, 0, 32'h0,  0,  1, 0, 1, 0, 32'hB,  32'h0,  32'h0,  2, 0, 0);
    vecs[2]  = mk(1, 0, 32'hC,  0, 0, 32'h0,  0,  1, 0, 1, 0, 32'hC,  32'h0,  32'h0,  3, 0, 0);
    vecs[3]  = mk(0, 1, 32'h0,  0, 0, 32'h0,  0,  1, 0, 0, 1, 32'h0,  32'hA,  32'h0,  2, 0, 0);
    vecs[4]  = mk(0, 1, 32'h0,  0, 0, 32'h0,  0,  1, 0, 0, 1, 32'h0,  32'hB,  32'h0,  1, 0, 0);
    vecs[5]  = mk(0, 1, 32'h0,  0, 0, 32'h0,  0,  1, 0, 0, 1, 32'h0,  32'hC,  32'h0,  0, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,  0, 1, 32'h0,  0,  0, 1, 0, 0, 32'h0,  32'h0,  32'h0,  0, 0, 1);
    vecs[7]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1,  0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  0, 0, 0);
    vecs[8]  = mk(0, 0, 32'h0,  0, 1, 32'h0,  1,  0, 1, 0, 0, 32'h0,  32'h0,  32'h0,  0, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1,  0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  0, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,  1, 1, 32'h55, 0,  0, 1, 1, 0, 32'h55, 32'h0,  32'h0,  1, 0, 1);
    vecs[11] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0,  0, 1, 0, 1, 32'h0,  32'h0,  32'h55, 0, 0, 1);
    vecs[12] = mk(0, 0, 32'h0,  0, 0, 32'h0,  1,  0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  0, 0, 0);
    vecs[13] = mk(1, 0, 32'h11, 1, 0, 32'h22, 0,  1, 0, 1, 0, 32'h11, 32'h0,  32'h0,  1, 0, 0);
    vecs[14] = mk(1, 0, 32'h33, 1, 0, 32'h44, 0,  0, 1, 1, 0, 32'h44, 32'h0,  32'h0,  2, 0, 0);
    vecs[15] = mk(0, 1, 32'h0,  0, 1, 32'h0,  0,  1, 0, 0, 1, 32'h0,  32'h11, 32'h0,  1, 0, 0);
    vecs[16] = mk(0, 1, 32'h0,  0, 1, 32'h0,  0,  0, 1, 0, 1, 32'h0,  32'h0,  32'h44, 0, 0, 0);

    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chkState("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      setIn(vecs[i].push0, vecs[i].pop0, vecs[i].wd0,
            vecs[i].push1, vecs[i].pop1, vecs[i].wd1, vecs[i].clr);
      #1;
      chk($sformatf("v%0d gnt0", i), 32'(bus.gnt0), 32'(vecs[i].g0));
      chk($sformatf("v%0d gnt1", i), 32'(bus.gnt1), 32'(vecs[i].g1));
      chk($sformatf("v%0d we", i), 32'(bus.fifoWriteEnable), 32'(vecs[i].we));
      chk($sformatf("v%0d re", i), 32'(bus.fifoReadEnable), 32'(vecs[i].re));
      chk($sformatf("v%0d wdata", i), bus.fifoWriteData, vecs[i].wdata);
      chk($sformatf("v%0d rd0", i), bus.req0RData, vecs[i].rd0);
      chk($sformatf("v%0d rd1", i), bus.req1RData, vecs[i].rd1);
      @(posedge clk);
      #1;
      chkState($sformatf("v%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
    end

    // Both ports push every cycle: strict alternation, stalled data held.
    k0 = 32'h100;
    k1 = 32'h200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      setIn(1, 0, k0, 1, 0, k1, 0);
      #1;
      expG0 = (i % 2 == 0);
      expW  = expG0 ? k0 : k1;
      chk($sformatf("alt%0d gnt0", i), 32'(bus.gnt0), 32'(expG0));
      chk($sformatf("alt%0d gnt1", i), 32'(bus.gnt1), 32'(!expG0));
      chk($sformatf("alt%0d wdata", i), bus.fifoWriteData, expW);
      @(posedge clk);
      #1;
      chk($sformatf("alt%0d count", i), 32'(bus.count), 32'(i + 1));
      if (expG0) k0 = k0 + 1;
      else       k1 = k1 + 1;
    end
    chk("alt full", 32'(bus.full), 32'd1);
    @(negedge clk);
    setIn(1, 0, k0, 1, 0, k1, 0);
    #1;
    chk("ovf gnt0", 32'(bus.gnt0), 32'd1);
    chk("ovf we", 32'(bus.fifoWriteEnable), 32'd0);
    @(posedge clk);
    #1;
    chkState("ovf", 4'd8, 1'b1, 1'b0);
    @(negedge clk);
    setIn(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chkState("ovfclr", 4'd8, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      setIn(0, 1, 0, 0, 0, 0, 0);
      #1;
      expW = (j % 2 == 0) ? (32'h100 + 32'(j / 2)) : (32'h200 + 32'(j / 2));
      chk($sformatf("drain%0d rd0", j), bus.req0RData, expW);
      @(posedge clk);
    end
    #1;
    chkState("drained", 4'd0, 1'b0, 1'b0);

    // Full FIFO of 1..8, then push+pop of 0x99.
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      setIn(1, 0, 32'(j), 0, 0, 0, 0);
      @(posedge clk);
    end
    #1;
    chk("fill full", 32'(bus.full), 32'd1);
    @(negedge clk);
    setIn(1, 1, 32'h99, 0, 0, 0, 0);
    #1;
    chk("pp rd0", bus.req0RData, 32'h1);
    chk("pp we", 32'(bus.fifoWriteEnable), 32'd1);
    chk("pp re", 32'(bus.fifoReadEnable), 32'd1);
    @(posedge clk);
    #1;
    chkState("pp", 4'd8, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      setIn(0, 1, 0, 0, 0, 0, 0);
      #1;
      expW = (j < 7) ? 32'(j + 2) : 32'h99;
      chk($sformatf("pop%0d rd0", j), bus.req0RData, expW);
      @(posedge clk);
    end
    #1;
    chkState("ppdrained", 4'd0, 1'b0, 1'b0);

    // Raise an error, push 5 words, then reset asynchronously mid-cycle.
    @(negedge clk);
    setIn(0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chkState("preRst udf", 4'd0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      setIn(1, 0, 32'h70 + 32'(j), 0, 0, 0, 0);
      @(posedge clk);
    end
    #1;
    chk("preRst count", 32'(bus.count), 32'd5);
    @(negedge clk);
    setIn(0, 1, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chkState("midRst", 4'd0, 1'b0, 1'b0);
    chk("midRst prio", 32'(dut.prio), 32'd0);
    chk("midRst gnt0", 32'(bus.gnt0), 32'd1);
    chk("midRst re", 32'(bus.fifoReadEnable), 32'd0);
    chk("midRst rd0", bus.req0RData, 32'h0);
    @(posedge clk);
    #1;
    chk("inRst count", 32'(bus.count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    setIn(1, 0, 32'hE0, 1, 0, 32'hE1, 0);
    #1;
    chk("postRst gnt0", 32'(bus.gnt0), 32'd1);
    chk("postRst gnt1", 32'(bus.gnt1), 32'd0);
    chk("postRst wdata", bus.fifoWriteData, 32'hE0);
    @(posedge clk);
    #1;
    chk("postRst count", 32'(bus.count), 32'd1);
    @(negedge clk);
    #1;
    chk("postRst2 gnt1", 32'(bus.gnt1), 32'd1);
    @(posedge clk);
    #1;
    chk("postRst2 count", 32'(bus.count), 32'd2);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
